// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// requester ids and default bus widths.
package data_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

endpackage

// File: rtl/data_memory_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that
// did not win last time is chosen.
module rr_pick2
  import data_mem_pkg::*;
(
  input  logic req_0,
  input  logic req_1,
  input  logic last_grant,
  output logic valid,
  output logic grant_id
);

  always_comb begin
    valid    = req_0 | req_1;
    grant_id = REQ_CPU;
    if (req_0 && req_1) begin
      grant_id = ~last_grant;
    end else if (req_1) begin
      grant_id = REQ_LDR;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter/sequencer for the shared data memory: latch one
// request, drive the memory for one cycle from registers, then acknowledge.
module data_memory_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_0,
  input  logic                  write_0,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  output logic                  ack_0,
  input  logic                  req_1,
  input  logic                  write_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic                  ack_1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  enable_write,
  output logic                  enable_read,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data
);

  state_t                r_state;
  logic                  r_last_grant;
  logic                  r_grant;
  logic                  r_ack_0;
  logic                  r_ack_1;
  logic                  r_busy;
  logic                  r_en_w;
  logic                  r_en_r;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_write_data;
  logic [DATA_WIDTH-1:0] r_rdata;

  state_t                w_state_next;
  logic                  w_last_grant_next;
  logic                  w_grant_next;
  logic                  w_ack_0_next;
  logic                  w_ack_1_next;
  logic                  w_busy_next;
  logic                  w_en_w_next;
  logic                  w_en_r_next;
  logic [ADDR_WIDTH-1:0] w_ram_addr_next;
  logic [DATA_WIDTH-1:0] w_write_data_next;
  logic [DATA_WIDTH-1:0] w_rdata_next;

  logic                  w_pick_valid;
  logic                  w_pick_id;

  rr_pick2 u_pick (
    .req_0      (req_0),
    .req_1      (req_1),
    .last_grant (r_last_grant),
    .valid      (w_pick_valid),
    .grant_id   (w_pick_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= REQ_LDR;
      r_grant      <= REQ_CPU;
      r_ack_0      <= 1'b0;
      r_ack_1      <= 1'b0;
      r_busy       <= 1'b0;
      r_en_w       <= 1'b0;
      r_en_r       <= 1'b0;
      r_ram_addr   <= '0;
      r_write_data <= '0;
      r_rdata      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
      r_grant      <= w_grant_next;
      r_ack_0      <= w_ack_0_next;
      r_ack_1      <= w_ack_1_next;
      r_busy       <= w_busy_next;
      r_en_w       <= w_en_w_next;
      r_en_r       <= w_en_r_next;
      r_ram_addr   <= w_ram_addr_next;
      r_write_data <= w_write_data_next;
      r_rdata      <= w_rdata_next;
    end
  end

  // Memory-port registers are loaded at the grant edge so the memory sees
  // clean, registered controls for the whole ACCESS cycle.
  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_grant_next      = r_grant;
    w_ack_0_next      = 1'b0;
    w_ack_1_next      = 1'b0;
    w_busy_next       = r_busy;
    w_en_w_next       = 1'b0;
    w_en_r_next       = 1'b0;
    w_ram_addr_next   = r_ram_addr;
    w_write_data_next = r_write_data;
    w_rdata_next      = r_rdata;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_next      = ACCESS;
          w_grant_next      = w_pick_id;
          w_busy_next       = 1'b1;
          w_en_w_next       = w_pick_id ? write_1 : write_0;
          w_en_r_next       = w_pick_id ? ~write_1 : ~write_0;
          w_ram_addr_next   = w_pick_id ? addr_1 : addr_0;
          w_write_data_next = w_pick_id ? wdata_1 : wdata_0;
        end
      end
      ACCESS: begin
        w_state_next = ACK;
        if (r_en_r) begin
          w_rdata_next = read_data;
        end
        w_ack_0_next = (r_grant == REQ_CPU);
        w_ack_1_next = (r_grant == REQ_LDR);
      end
      ACK: begin
        w_state_next      = IDLE;
        w_busy_next       = 1'b0;
        w_last_grant_next = r_grant;
      end
      default: begin
        w_state_next = IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  assign ack_0        = r_ack_0;
  assign ack_1        = r_ack_1;
  assign busy         = r_busy;
  assign enable_write = r_en_w;
  assign enable_read  = r_en_r;
  assign ram_addr     = r_ram_addr;
  assign write_data   = r_write_data;
  assign rdata        = r_rdata;

endmodule
